// File: rtl/vend_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispenser
// Purpose  : Queues cola/change requests and drives the cola motor and the
//            coin-return solenoid with timed, handshaked pulses.
//            Optional macro VEND_COUNT_EN adds the po_vend_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module vend_dispenser #(
    parameter int SOL_CYC     = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 16,
    parameter int PEND_W      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pi_cola,
    input  logic        pi_money,
    input  logic        motor_done,
    output logic        po_motor_on,
    output logic        po_coin_sol,
    output logic        po_busy,
    output logic        po_fault,
    output logic        po_ovf
`ifdef VEND_COUNT_EN
    ,
    output logic [15:0] po_vend_cnt
`endif
);

    localparam int c_TMR_MAX = (TIMEOUT_CYC > SOL_CYC) ?
                               ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) :
                               ((SOL_CYC > GAP_CYC) ? SOL_CYC : GAP_CYC);
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_SOL_LAST = c_TMR_W'(SOL_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST = c_TMR_W'(GAP_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
    localparam logic [PEND_W-1:0]  c_PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0]  c_PEND_ONE = PEND_W'(1);

    localparam logic [5:0] c_IDLE       = 6'b000001;
    localparam logic [5:0] c_VEND       = 6'b000010;
    localparam logic [5:0] c_VEND_GAP   = 6'b000100;
    localparam logic [5:0] c_CHANGE     = 6'b001000;
    localparam logic [5:0] c_CHANGE_GAP = 6'b010000;
    localparam logic [5:0] c_FAULT      = 6'b100000;

    logic [5:0]         r_state;
    logic [5:0]         w_state_nxt;
    logic [5:0]         w_pick;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_TMR_W-1:0] w_tmr_nxt;
    logic [PEND_W-1:0]  r_cola_pend;
    logic [PEND_W-1:0]  r_coin_pend;
    logic               w_cola_dec;
    logic               w_coin_dec;
    logic               w_ovf_set;
    logic               w_motor_on;
    logic               w_coin_sol;
    logic               w_busy;
    logic               w_fault;
    logic               r_motor_on;
    logic               r_coin_sol;
    logic               r_busy;
    logic               r_fault;
    logic               r_ovf;

    // Cola always wins over change when both are owed.
    assign w_pick = (r_cola_pend != '0) ? c_VEND :
                    (r_coin_pend != '0) ? c_CHANGE : c_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = '0;
        w_cola_dec  = 1'b0;
        w_coin_dec  = 1'b0;
        case (r_state)
            c_IDLE: w_state_nxt = w_pick;
            c_VEND: begin
                if (motor_done) begin
                    w_state_nxt = c_VEND_GAP;
                    w_cola_dec  = 1'b1;
                end else if (r_tmr == c_TO_LAST) begin
                    w_state_nxt = c_FAULT;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_ONE;
                end
            end
            c_CHANGE: begin
                if (r_tmr == c_SOL_LAST) begin
                    w_state_nxt = c_CHANGE_GAP;
                    w_coin_dec  = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_ONE;
                end
            end
            c_VEND_GAP, c_CHANGE_GAP: begin
                if (r_tmr == c_GAP_LAST) begin
                    w_state_nxt = w_pick;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_ONE;
                end
            end
            c_FAULT: w_state_nxt = c_FAULT;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Drives are decoded from the next state so they switch with the state.
    always_comb begin
        w_motor_on = (w_state_nxt == c_VEND);
        w_coin_sol = (w_state_nxt == c_CHANGE);
        w_busy     = (w_state_nxt != c_IDLE);
        w_fault    = (w_state_nxt == c_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_motor_on <= 1'b0;
            r_coin_sol <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_motor_on <= w_motor_on;
            r_coin_sol <= w_coin_sol;
            r_busy     <= w_busy;
            r_fault    <= w_fault;
        end
    end

    // An increment with a simultaneous decrement is a net no-op, never an overflow.
    assign w_ovf_set = (pi_cola  && !w_cola_dec && (r_cola_pend == c_PEND_MAX)) ||
                       (pi_money && !w_coin_dec && (r_coin_pend == c_PEND_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cola_pend <= '0;
            r_coin_pend <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (pi_cola && !w_cola_dec && (r_cola_pend != c_PEND_MAX)) begin
                r_cola_pend <= r_cola_pend + c_PEND_ONE;
            end else if (!pi_cola && w_cola_dec) begin
                r_cola_pend <= r_cola_pend - c_PEND_ONE;
            end
            if (pi_money && !w_coin_dec && (r_coin_pend != c_PEND_MAX)) begin
                r_coin_pend <= r_coin_pend + c_PEND_ONE;
            end else if (!pi_money && w_coin_dec) begin
                r_coin_pend <= r_coin_pend - c_PEND_ONE;
            end
            r_ovf <= r_ovf | w_ovf_set;
        end
    end

    assign po_motor_on = r_motor_on;
    assign po_coin_sol = r_coin_sol;
    assign po_busy     = r_busy;
    assign po_fault    = r_fault;
    assign po_ovf      = r_ovf;

`ifdef VEND_COUNT_EN
    logic [15:0] r_vend_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vend_cnt <= 16'd0;
        end else if (w_cola_dec) begin
            r_vend_cnt <= r_vend_cnt + 16'd1;
        end
    end

    assign po_vend_cnt = r_vend_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vend_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_dispenser
// Purpose  : Self-checking bench for vend_dispenser (vector table, directed
//            corner sequences, randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_dispenser;

    localparam int SOL_CYC     = 4;
    localparam int GAP_CYC     = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int PEND_W      = 3;
    localparam int PEND_MAX    = (1 << PEND_W) - 1;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic pi_cola    = 1'b0;
    logic pi_money   = 1'b0;
    logic motor_done = 1'b0;
    logic po_motor_on;
    logic po_coin_sol;
    logic po_busy;
    logic po_fault;
    logic po_ovf;
`ifdef VEND_COUNT_EN
    logic [15:0] po_vend_cnt;
`endif

    always #5 clk = ~clk;

    vend_dispenser #(
        .SOL_CYC     (SOL_CYC),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .PEND_W      (PEND_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pi_cola     (pi_cola),
        .pi_money    (pi_money),
        .motor_done  (motor_done),
        .po_motor_on (po_motor_on),
        .po_coin_sol (po_coin_sol),
        .po_busy     (po_busy),
        .po_fault    (po_fault),
        .po_ovf      (po_ovf)
`ifdef VEND_COUNT_EN
        ,
        .po_vend_cnt (po_vend_cnt)
`endif
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [4:0] outs();
        return {po_motor_on, po_coin_sol, po_busy, po_fault, po_ovf};
    endfunction

    // Reference model: owed counts plus "what the machine is doing and how
    // many cycles of that activity remain".
    typedef enum int {ACT_NONE, ACT_MOTOR, ACT_REST, ACT_COIN, ACT_DEAD} act_t;
    act_t m_act;
    int   m_left;
    int   m_cola;
    int   m_coin;
    bit   m_ovf;

    task automatic model_reset();
        m_act  = ACT_NONE;
        m_left = 0;
        m_cola = 0;
        m_coin = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_pick();
        if (m_cola > 0) begin
            m_act  = ACT_MOTOR;
            m_left = TIMEOUT_CYC;
        end else if (m_coin > 0) begin
            m_act  = ACT_COIN;
            m_left = SOL_CYC;
        end else begin
            m_act = ACT_NONE;
        end
    endtask

    task automatic model_step(input logic c, input logic m, input logic d);
        bit dec_c;
        bit dec_m;
        dec_c = 1'b0;
        dec_m = 1'b0;
        case (m_act)
            ACT_NONE: model_pick();
            ACT_MOTOR: begin
                if (d) begin
                    dec_c  = 1'b1;
                    m_act  = ACT_REST;
                    m_left = GAP_CYC;
                end else if (m_left == 1) m_act = ACT_DEAD;
                else m_left--;
            end
            ACT_COIN: begin
                if (m_left == 1) begin
                    dec_m  = 1'b1;
                    m_act  = ACT_REST;
                    m_left = GAP_CYC;
                end else m_left--;
            end
            ACT_REST: begin
                if (m_left == 1) model_pick();
                else m_left--;
            end
            default: ;
        endcase
        if (c && !dec_c) begin
            if (m_cola == PEND_MAX) m_ovf = 1'b1;
            else m_cola++;
        end else if (!c && dec_c) m_cola--;
        if (m && !dec_m) begin
            if (m_coin == PEND_MAX) m_ovf = 1'b1;
            else m_coin++;
        end else if (!m && dec_m) m_coin--;
    endtask

    function automatic logic [4:0] model_outs();
        return {m_act == ACT_MOTOR, m_act == ACT_COIN, m_act != ACT_NONE,
                m_act == ACT_DEAD, m_ovf};
    endfunction

    // One clock: drive, step the model on the edge, compare on the falling edge.
    task automatic tick(input logic c, input logic m, input logic d);
        pi_cola    = c;
        pi_money   = m;
        motor_done = d;
        @(posedge clk);
        model_step(c, m, d);
        @(negedge clk);
        check("model", outs(), model_outs());
    endtask

    task automatic do_reset();
        pi_cola    = 1'b0;
        pi_money   = 1'b0;
        motor_done = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       c;
        logic       m;
        logic       d;
        logic [4:0] exp;   // {motor, sol, busy, fault, ovf}
    } vec_t;

    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int on_cnt;
        int gap;
        int hi;
        int lo;
        int pulses;
        int k_target;
        logic prev;
        logic c;
        logic m;
        logic d;

        // Cola+coin together, spurious done in a gap, cola arriving mid change-out.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'b00000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 5'b10100};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 5'b10100};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 5'b00100};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 5'b00100};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 5'b01100};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'b01100};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 5'b01100};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 5'b01100};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 5'b00100};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 5'b00100};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 5'b10100};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 5'b00100};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 5'b00100};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 5'b00000};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            tick(tbl[i].c, tbl[i].m, tbl[i].d);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // Single cola, motor_done on the 5th motor cycle.
        do_reset();
        tick(1'b1, 1'b0, 1'b0);
        for (int w = 0; w < 5 && !po_motor_on; w++) tick(1'b0, 1'b0, 1'b0);
        check("motor_start", po_motor_on, 1);
        on_cnt = 1;
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 1'b0, k == 5);
            if (po_motor_on) on_cnt++;
        end
        check("motor_len", on_cnt, 5);
        gap = 0;
        while (po_busy && !po_motor_on && !po_coin_sol && gap < 6) begin
            gap++;
            tick(1'b0, 1'b0, 1'b0);
        end
        check("vend_gap_len", gap, GAP_CYC);
        check("idle_after_vend", po_busy, 0);

        // Three back-to-back coins.
        do_reset();
        hi = 0; lo = 0; pulses = 0; prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, i < 3, 1'b0);
            if (po_coin_sol) begin
                if (!prev && pulses > 0) check("sol_gap", lo, GAP_CYC);
                hi++;
            end else begin
                if (prev) begin
                    check("sol_len", hi, SOL_CYC);
                    pulses++;
                    hi = 0;
                    lo = 0;
                end
                lo++;
            end
            prev = po_coin_sol;
        end
        check("sol_pulses", pulses, 3);

        // Eight colas with a dead motor: saturation then timeout fault.
        do_reset();
        on_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (po_motor_on) on_cnt++;
        end
        check("ovf_set", po_ovf, 1);
        for (int i = 0; i < 30 && !po_fault; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (po_motor_on) on_cnt++;
        end
        check("timeout_len", on_cnt, TIMEOUT_CYC);
        check("fault_outs", outs(), 5'b00111);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1);
        check("fault_sticky", outs(), 5'b00111);

        // Asynchronous reset in the second solenoid cycle.
        do_reset();
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("sol_before_rst", po_coin_sol, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", outs(), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        check("idle_after_rst", outs(), 0);

        // Randomized traffic with a motor that finishes after 1..10 cycles.
        do_reset();
        on_cnt = 0;
        k_target = 1;
        for (int i = 0; i < 800; i++) begin
            c = ($urandom_range(0, 11) == 0);
            m = ($urandom_range(0, 9) == 0);
            if (po_motor_on) begin
                on_cnt++;
                d = (on_cnt >= k_target);
            end else begin
                on_cnt = 0;
                k_target = $urandom_range(1, 10);
                d = ($urandom_range(0, 7) == 0);
            end
            tick(c, m, d);
        end

`ifdef VEND_COUNT_EN
        do_reset();
        for (int i = 0; i < 30; i++) tick(i < 3, 1'b0, 1'b1);
        check("vend_cnt3", po_vend_cnt, 3);
        force dut.r_vend_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_vend_cnt;
        for (int i = 0; i < 8; i++) tick(i == 0, 1'b0, 1'b1);
        check("vend_cnt_wrap", po_vend_cnt, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
